// File: rtl/i2c_slave.sv
// Single-address I2C slave on an open-drain SDA/SCL pair.
// Oversamples SCL/SDA on clk (clk must be >= 8x SCL), detects START, repeated START and STOP,
// matches a 7-bit address, accepts write bytes and serves read bytes with per-byte ACK/NACK.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   sda            open-drain data line; this block only pulls low or releases
//   scl            serial clock from the master (no stretching)
//   bus_in_slave   byte returned to the master on a read
//   bus_out_slave  last byte written by the master
//   wr_valid       one-clk pulse when bus_out_slave is updated
//   rd_req         one-clk pulse when bus_in_slave has been captured for transmission
//   busy           high from an address match until STOP or NACK
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        sda,
  input  logic       scl,
  input  logic [7:0] bus_in_slave,
  output logic [7:0] bus_out_slave,
  output logic       wr_valid,
  output logic       rd_req,
  output logic       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] WRITE_ACK = 3'd4;
  localparam logic [2:0] READ      = 3'd5;
  localparam logic [2:0] READ_ACK  = 3'd6;

  // 2-FF synchronizers plus one history stage for edge detection. Reset to the idle bus level
  // so releasing reset never fabricates an edge.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  logic [2:0] state_q, state_d;
  logic [2:0] bit_count_q, bit_count_d;
  logic [6:0] shift_q, shift_d;     // first 7 bits of the byte being received
  logic [6:0] tx_q, tx_d;           // bits still to be sent, MSB first
  logic       rw_q, rw_d;
  logic       byte_done_q, byte_done_d;  // 8 bits seen (or master ACK seen), waiting for SCL fall
  logic       drive_low_q, drive_low_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       wr_valid_q, wr_valid_d;
  logic       rd_req_q, rd_req_d;
  logic       busy_q, busy_d;

  logic [7:0] shift_in;
  assign shift_in = {shift_q, sda_s};

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    byte_done_d = byte_done_q;
    drive_low_d = drive_low_q;
    bus_out_d   = bus_out_q;
    wr_valid_d  = 1'b0;
    rd_req_d    = 1'b0;
    busy_d      = busy_q;

    if (start_det) begin
      state_d     = ADDR;
      bit_count_d = 3'd0;
      byte_done_d = 1'b0;
      drive_low_d = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE;
      bit_count_d = 3'd0;
      byte_done_d = 1'b0;
      drive_low_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise && !byte_done_q) begin
            shift_d = shift_in[6:0];
            if (bit_count_q == 3'd7) begin
              if (shift_in[7:1] == SLAVE_ADDR) begin
                rw_d        = shift_in[0];
                byte_done_d = 1'b1;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              bit_count_d = bit_count_q + 3'd1;
            end
          end else if (scl_fall && byte_done_q) begin
            drive_low_d = 1'b1;
            busy_d      = 1'b1;
            byte_done_d = 1'b0;
            state_d     = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_count_d = 3'd0;
            if (rw_q) begin
              tx_d        = bus_in_slave[6:0];
              rd_req_d    = 1'b1;
              drive_low_d = ~bus_in_slave[7];
              state_d     = READ;
            end else begin
              drive_low_d = 1'b0;
              state_d     = WRITE;
            end
          end
        end
        WRITE: begin
          if (scl_rise && !byte_done_q) begin
            shift_d = shift_in[6:0];
            if (bit_count_q == 3'd7) begin
              bus_out_d   = shift_in;
              wr_valid_d  = 1'b1;
              byte_done_d = 1'b1;
            end else begin
              bit_count_d = bit_count_q + 3'd1;
            end
          end else if (scl_fall && byte_done_q) begin
            drive_low_d = 1'b1;
            byte_done_d = 1'b0;
            state_d     = WRITE_ACK;
          end
        end
        WRITE_ACK: begin
          if (scl_fall) begin
            drive_low_d = 1'b0;
            bit_count_d = 3'd0;
            state_d     = WRITE;
          end
        end
        READ: begin
          if (scl_fall) begin
            // bit_count counts bits already put on the bus after the MSB
            if (bit_count_q == 3'd7) begin
              drive_low_d = 1'b0;
              bit_count_d = 3'd0;
              byte_done_d = 1'b0;
              state_d     = READ_ACK;
            end else begin
              drive_low_d = ~tx_q[6];
              tx_d        = {tx_q[5:0], 1'b0};
              bit_count_d = bit_count_q + 3'd1;
            end
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              drive_low_d = 1'b0;
              busy_d      = 1'b0;
              state_d     = IDLE;
            end else begin
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            tx_d        = bus_in_slave[6:0];
            rd_req_d    = 1'b1;
            drive_low_d = ~bus_in_slave[7];
            bit_count_d = 3'd0;
            byte_done_d = 1'b0;
            state_d     = READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_count_q <= 3'd0;
      shift_q     <= 7'd0;
      tx_q        <= 7'd0;
      rw_q        <= 1'b0;
      byte_done_q <= 1'b0;
      drive_low_q <= 1'b0;
      bus_out_q   <= 8'd0;
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      byte_done_q <= byte_done_d;
      drive_low_q <= drive_low_d;
      bus_out_q   <= bus_out_d;
      wr_valid_q  <= wr_valid_d;
      rd_req_q    <= rd_req_d;
      busy_q      <= busy_d;
    end
  end

  // drive_low is a flop with async reset, so reset releases SDA without waiting for clk
  assign sda           = drive_low_q ? 1'b0 : 1'bz;
  assign bus_out_slave = bus_out_q;
  assign wr_valid      = wr_valid_q;
  assign rd_req        = rd_req_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;

  localparam int Q = 4;  // clk cycles per quarter SCL period
  localparam logic [6:0] SLV = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;  // 1 = master releases SDA
  logic [7:0] bus_in_slave = 8'h00;
  wire  [7:0] bus_out_slave;
  wire        wr_valid, rd_req, busy;
  wire        sda_bus;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(SLV)) dut (
    .clk          (clk),
    .rst          (rst),
    .sda          (sda_bus),
    .scl          (scl),
    .bus_in_slave (bus_in_slave),
    .bus_out_slave(bus_out_slave),
    .wr_valid     (wr_valid),
    .rd_req       (rd_req),
    .busy         (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Bus monitors, sampled on the falling clk edge away from DUT updates.
  int   wr_cnt = 0, rd_cnt = 0, overlap_cnt = 0, long_cnt = 0, pull_cnt = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_valid === 1'b1) wr_cnt++;
    if (rd_req === 1'b1) rd_cnt++;
    if (wr_valid === 1'b1 && rd_req === 1'b1) overlap_cnt++;
    if ((wr_valid === 1'b1 && wr_prev) || (rd_req === 1'b1 && rd_prev)) long_cnt++;
    if (m_sda && sda_bus !== 1'b1) pull_cnt++;
    wr_prev = (wr_valid === 1'b1);
    rd_prev = (rd_req === 1'b1);
  end

  // Reference model state: what bus_out_slave must hold given accepted writes.
  logic [7:0] model_out = 8'h00;

  function automatic logic model_ack(input logic [7:0] addr_byte);
    return (addr_byte[7:1] == SLV) ? 1'b0 : 1'b1;
  endfunction

  // ---------------- bus master ----------------
  task automatic q_wait();
    repeat (Q) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q_wait();
    scl = 1'b1;   q_wait();
    m_sda = 1'b0; q_wait();
    scl = 1'b0;   q_wait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q_wait();
    scl = 1'b1;   q_wait();
    m_sda = 1'b1; q_wait();
    q_wait();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; q_wait();
    scl = 1'b1; q_wait();
    q_wait();
    scl = 1'b0; q_wait();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; q_wait();
    scl = 1'b1;   q_wait();
    b = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    q_wait();
    scl = 1'b0;   q_wait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(master_ack ? 1'b0 : 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) q_wait();
    vectors++;
    if ({bus_out_slave, wr_valid, rd_req, busy} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 000", {bus_out_slave, wr_valid, rd_req, busy});
    end
    vectors++;
    if (sda_bus !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_sda: got %b expected 1", sda_bus);
    end
    rst = 1'b0;
    q_wait();
  endtask

  task automatic test_write_one(input logic [7:0] data);
    logic ack;
    int   w0;
    i2c_start();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL wr1_busy_before: got %b expected 0", busy);
    end
    write_byte(8'hA0, ack);
    vectors++;
    if (ack !== model_ack(8'hA0)) begin
      miscompares++; $display("FAIL wr1_addr_ack: got %b expected %b", ack, model_ack(8'hA0));
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL wr1_busy_after_ack: got %b expected 1", busy);
    end
    w0 = wr_cnt;
    write_byte(data, ack);
    model_out = data;
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++; $display("FAIL wr1_data_ack: got %b expected 0", ack);
    end
    vectors++;
    if (bus_out_slave !== model_out) begin
      miscompares++; $display("FAIL wr1_data: got %h expected %h", bus_out_slave, model_out);
    end
    vectors++;
    if (wr_cnt - w0 !== 1) begin
      miscompares++; $display("FAIL wr1_pulses: got %0d expected 1", wr_cnt - w0);
    end
    i2c_stop();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL wr1_busy_stop: got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic       ack;
    logic [7:0] d;
    int         w0;
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++; $display("FAIL b2b_addr_ack: got %b expected 0", ack);
    end
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      write_byte(d, ack);
      model_out = d;
      vectors++;
      if (ack !== 1'b0 || bus_out_slave !== model_out) begin
        miscompares++;
        $display("FAIL b2b_byte%0d: got ack=%b data=%h expected ack=0 data=%h",
                 k, ack, bus_out_slave, model_out);
      end
    end
    i2c_stop();
    vectors++;
    if (wr_cnt - w0 !== n) begin
      miscompares++; $display("FAIL b2b_pulses: got %0d expected %0d", wr_cnt - w0, n);
    end
  endtask

  task automatic test_wrong_addr(input logic [7:0] addr);
    logic ack, ack2;
    int   w0, p0;
    w0 = wr_cnt;
    p0 = pull_cnt;
    i2c_start();
    write_byte(addr, ack);
    write_byte(8'($urandom), ack2);
    vectors++;
    if (ack !== model_ack(addr) || ack2 !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_addr_ack(%h): got %b%b expected %b1", addr, ack, ack2, model_ack(addr));
    end
    vectors++;
    if (pull_cnt - p0 !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_addr_silent: got pulls=%0d busy=%b expected pulls=0 busy=0",
               pull_cnt - p0, busy);
    end
    i2c_stop();
    vectors++;
    if (wr_cnt - w0 !== 0 || bus_out_slave !== model_out) begin
      miscompares++;
      $display("FAIL bad_addr_write: got pulses=%0d data=%h expected pulses=0 data=%h",
               wr_cnt - w0, bus_out_slave, model_out);
    end
  endtask

  task automatic test_read_two(input logic [7:0] b1, input logic [7:0] b2);
    logic       ack;
    logic [7:0] d1, d2;
    int         r0;
    r0 = rd_cnt;
    bus_in_slave = b1;
    i2c_start();
    write_byte(8'hA1, ack);
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++; $display("FAIL rd_addr_ack: got %b expected 0", ack);
    end
    bus_in_slave = b2;
    read_byte(d1, 1'b1);
    read_byte(d2, 1'b0);
    vectors++;
    if (d1 !== b1) begin
      miscompares++; $display("FAIL rd_byte1: got %h expected %h", d1, b1);
    end
    vectors++;
    if (d2 !== b2) begin
      miscompares++; $display("FAIL rd_byte2: got %h expected %h", d2, b2);
    end
    vectors++;
    if (rd_cnt - r0 !== 2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_end: got rd_req=%0d busy=%b expected rd_req=2 busy=0", rd_cnt - r0, busy);
    end
    i2c_stop();
  endtask

  task automatic test_repeated_start();
    logic       ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h11, ack);
    model_out = 8'h11;
    vectors++;
    if (bus_out_slave !== model_out) begin
      miscompares++; $display("FAIL rs_write: got %h expected %h", bus_out_slave, model_out);
    end
    bus_in_slave = 8'hE7;
    i2c_start();
    write_byte(8'hA1, ack);
    vectors++;
    if (ack !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL rs_rematch: got ack=%b busy=%b expected ack=0 busy=1", ack, busy);
    end
    read_byte(d, 1'b0);
    vectors++;
    if (d !== 8'hE7 || bus_out_slave !== model_out) begin
      miscompares++;
      $display("FAIL rs_read: got %h out=%h expected e7 out=%h", d, bus_out_slave, model_out);
    end
    i2c_stop();
  endtask

  task automatic test_early_stop();
    logic ack;
    int   w0;
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    i2c_stop();
    vectors++;
    if (wr_cnt - w0 !== 0 || busy !== 1'b0 || sda_bus !== 1'b1 || bus_out_slave !== model_out) begin
      miscompares++;
      $display("FAIL early_stop: got pulses=%0d busy=%b sda=%b out=%h expected 0 0 1 %h",
               wr_cnt - w0, busy, sda_bus, bus_out_slave, model_out);
    end
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h5A, ack);
    model_out = 8'h5A;
    i2c_stop();
    vectors++;
    if (ack !== 1'b0 || bus_out_slave !== model_out) begin
      miscompares++;
      $display("FAIL early_stop_next: got ack=%b out=%h expected ack=0 out=%h", ack, bus_out_slave,
               model_out);
    end
  endtask

  task automatic test_reset_mid_read();
    logic       ack;
    logic [8:0] got;
    logic [7:0] d;
    int         p0, r0;
    bus_in_slave = 8'($urandom) & 8'h7F;  // MSB 0 so the slave is pulling low
    i2c_start();
    write_byte(8'hA1, ack);
    m_sda = 1'b1; q_wait();
    scl = 1'b1;   q_wait();
    vectors++;
    if (sda_bus !== 1'b0) begin
      miscompares++; $display("FAIL rstrd_driving: got %b expected 0", sda_bus);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (sda_bus !== 1'b1) begin
      miscompares++; $display("FAIL rstrd_sda_async: got %b expected 1", sda_bus);
    end
    model_out = 8'h00;
    vectors++;
    if ({bus_out_slave, wr_valid, rd_req, busy} !== 11'd0) begin
      miscompares++;
      $display("FAIL rstrd_outputs: got %h expected 000", {bus_out_slave, wr_valid, rd_req, busy});
    end
    q_wait();
    rst = 1'b0;
    q_wait();
    scl = 1'b0; q_wait();
    p0 = pull_cnt;
    r0 = rd_cnt;
    for (int i = 8; i >= 0; i--) recv_bit(got[i]);
    vectors++;
    if (got !== 9'h1FF || pull_cnt - p0 !== 0 || rd_cnt - r0 !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstrd_ignore: got bits=%h pulls=%0d rd=%0d busy=%b expected 1ff 0 0 0",
               got, pull_cnt - p0, rd_cnt - r0, busy);
    end
    i2c_stop();
    d = 8'($urandom);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(d, ack);
    model_out = d;
    i2c_stop();
    vectors++;
    if (ack !== 1'b0 || bus_out_slave !== model_out) begin
      miscompares++;
      $display("FAIL rstrd_recover: got ack=%b out=%h expected ack=0 out=%h", ack, bus_out_slave,
               model_out);
    end
  endtask

  task automatic test_pulses();
    vectors++;
    if (overlap_cnt !== 0 || long_cnt !== 0) begin
      miscompares++;
      $display("FAIL pulse_shape: got overlap=%0d long=%0d expected 0 0", overlap_cnt, long_cnt);
    end
  endtask

  initial begin
    logic [7:0] a;
    #1;
    test_reset();
    test_write_one(8'h3C);
    test_write_one(8'($urandom));
    test_back_to_back(4);
    test_wrong_addr(8'hA2);
    for (int k = 0; k < 3; k++) begin
      a = 8'($urandom);
      if (a[7:1] == SLV) a[7:1] = a[7:1] ^ 7'h01;
      test_wrong_addr(a);
    end
    test_read_two(8'h96, 8'h0F);
    test_read_two(8'($urandom), 8'($urandom));
    test_repeated_start();
    test_early_stop();
    test_reset_mid_read();
    test_pulses();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
